// File: rtl/onehot_pkg.sv
// rtl/onehot_pkg.sv - shared one-hot word classification types and helpers
package onehot_pkg;

  typedef enum logic [1:0] {
    OK    = 2'd0,
    ZERO  = 2'd1,
    MULTI = 2'd2
  } kind_t;

  localparam int MAX_W  = 64;
  localparam int MAX_IW = 6;

  // Behavioural reference encoder; the highest index is scanned first so the lowest set bit wins.
  function automatic logic [MAX_IW-1:0] lowest_set_idx(input logic [MAX_W-1:0] v);
    logic [MAX_IW-1:0] idx;
    idx = '0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = MAX_IW'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_pipe_slice.sv
// rtl/onehot_pipe_slice.sv - generic valid/ready register slice
module onehot_pipe_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_val,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data
);

  assign in_rdy = !out_val || out_rdy;

  // Data only loads on a real transfer so the output holds its last value when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val  <= 1'b0;
      out_data <= '0;
    end else if (in_rdy) begin
      out_val <= in_val;
      if (in_val) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/onehot_to_bin.sv
// rtl/onehot_to_bin.sv - streaming one-hot to binary index decoder with error classification
module onehot_to_bin
  import onehot_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int CNT_W = 8,
  localparam int IW    = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [W-1:0]     in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [IW-1:0]    out_idx,
  output logic             out_err,
  output logic [1:0]       out_kind,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  logic          in_zero;
  logic          in_multi;
  kind_t         in_kind;

  logic          s1_val;
  logic          s1_rdy;
  logic [W+1:0]  s1_data;
  logic [W-1:0]  s1_word;
  kind_t         s1_kind;
  logic [W-1:0]  s1_iso;
  logic [IW-1:0] s1_idx;
  logic          s1_err;

  logic [IW+2:0] s2_data;

  assign in_zero  = ~|in_data;
  assign in_multi = |(in_data & (in_data - ONE_W));

  always_comb begin
    in_kind = OK;
    if (in_zero) begin
      in_kind = ZERO;
    end else if (in_multi) begin
      in_kind = MULTI;
    end
  end

  onehot_pipe_slice #(.DW(W + 2)) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  ({in_data, in_kind}),
    .out_val  (s1_val),
    .out_rdy  (s1_rdy),
    .out_data (s1_data)
  );

  assign s1_word = s1_data[W+1:2];
  assign s1_kind = kind_t'(s1_data[1:0]);
  assign s1_err  = (s1_kind != OK);

  // Two's-complement isolation keeps only the lowest set bit, so multi-hot words encode that bit.
  assign s1_iso = s1_word & (~s1_word + ONE_W);

  always_comb begin
    s1_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (s1_iso[i]) begin
        s1_idx = s1_idx | IW'(i);
      end
    end
  end

  onehot_pipe_slice #(.DW(IW + 3)) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (s1_val),
    .in_rdy   (s1_rdy),
    .in_data  ({s1_idx, s1_err, s1_kind}),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (s2_data)
  );

  assign out_idx  = s2_data[IW+2:3];
  assign out_err  = s2_data[2];
  assign out_kind = s2_data[1:0];

  // Clear takes priority over a coincident error delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_val && out_rdy && out_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: doc/onehot_to_bin.md
Name: onehot_to_bin

Overview:
- Streaming decoder that turns a one-hot vector into its binary bit index. It is the inverse of the codebase's one-hot isolator.
- Classifies each word as OK, ZERO or MULTI. It flags malformed words and keeps a saturating error count.
- Sits between a one-hot producer (priority isolator, arbiter grant) and index consumers (mux selects, table addresses), using valid/ready handshakes on both sides.

Parameters:
- W, 8, input vector width; legal range 2..64.
- IW, $clog2(W), output index width; derived, not overridden.
- CNT_W, 8, error counter width; minimum 2.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_val  input  1  upstream word valid.
- in_rdy  output  1  block can accept a word this cycle.
- in_data  input  W  one-hot (expected) vector.
- out_val  output  1  decoded result valid.
- out_rdy  input  1  downstream accepts result.
- out_idx  output  IW  binary index of the set bit.
- out_err  output  1  word was not exactly one-hot.
- out_kind  output  2  onehot_pkg::kind_t: OK=0, ZERO=1, MULTI=2.
- err_cnt  output  CNT_W  saturating count of erroneous words delivered.
- err_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset (rst_n low, asynchronous): s1_val, s2_val, out_val, out_idx, out_err, out_kind and err_cnt all go to 0. Pipeline contents are discarded.
- in_rdy is combinational and equals !s1_val || s1_adv, so it reads 1 while in reset and immediately after.
- Handshakes:
  - A transfer occurs on a cycle with val && rdy.
  - in_rdy must not depend on in_val.
  - out_val, once high, holds and out_idx/out_err/out_kind stay stable until out_rdy.
- Pipeline, two register slices:
  - S1 registers in_data plus kind: zero = ~|in_data; multi = more than one bit set, computed as (in_data & (in_data-1)) != 0.
  - S2 registers the index (OR-reduction encoder over the isolated lowest set bit), err and kind. S2 drives the out_* ports directly.
- Latency: exactly 2 cycles from input transfer to out_val with no stall. Throughput is 1 word/cycle when out_rdy is held 1.
- Advance rules:
  - s2_adv = s1_val && (!s2_val || out_rdy).
  - s1_adv = s2_adv.
  - S1 loads when in_val && in_rdy.
  - No bubbles are inserted. No combinational path from out_rdy to in_rdy beyond the advance chain; this is accepted.
- Result rules:
  - OK: out_idx = position of the single set bit; out_err = 0.
  - ZERO: out_idx = 0; out_err = 1.
  - MULTI: out_idx = position of the lowest set bit; out_err = 1.
- Error counter:
  - Increments on out_val && out_rdy && out_err.
  - Saturates at all-ones and never wraps.
  - err_clr wins over a simultaneous increment: the result is 0.
  - err_clr while idle sets the counter to 0.
- Reset asserted mid-stream: in-flight words are lost and no partial output is produced. The first input after reset emerges 2 cycles after its transfer.
- X-free: out_idx is a defined value even when out_val = 0; it holds its last value.

Decomposition:
- Package onehot_pkg:
  - typedef enum logic [1:0] kind_t {OK, ZERO, MULTI}.
  - function lowest_set_idx (parametric-width loop returning an index).
  - Shared with the isolator and future arbiter blocks.
- Sub-module onehot_pipe_slice:
  - Generic valid/ready register slice with parameter DW.
  - Instantiated twice here (S1, S2).
  - Reusable for other streaming blocks.
- Top onehot_to_bin contains the classification logic, the encoder and the error counter.

Test Plan:
- Walking one, W=8: apply 0x01..0x80 back-to-back with out_rdy=1 → out_idx 0..7, out_err=0, kind OK, first out_val 2 cycles after first transfer, then one result per cycle.
- Zero word: in_data=0x00 → out_idx=0, out_err=1, kind ZERO, err_cnt increments 0→1 on delivery.
- Multi-hot: in_data=0x28 → out_idx=3, out_err=1, kind MULTI; in_data=0xFF → out_idx=0, MULTI.
- Backpressure:
  - Send 0x04, 0x10, 0x40 while out_rdy=0 → in_rdy drops after two accepted, out_idx=2 held stable.
  - Release out_rdy → 2, 4, 6 delivered in order, none lost or duplicated.
- Saturation/clear, CNT_W=2:
  - Five ZERO words → err_cnt 1, 2, 3, 3, 3.
  - err_clr on the same cycle as an error delivery → err_cnt=0.
- Reset mid-stream: assert rst_n low with both stages full → outputs 0 immediately (asynchronous); after release, 0x02 → out_idx=1 after 2 cycles, with no stale word.
